axi_rd_arbiter: RTL

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter_pkg.sv | 15 +
 rtl/axi_rd_arbiter_rr_arbiter.sv | 46 ++++
 rtl/axi_rd_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the AXI read-port arbiter.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rd_state_e;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_EXOKAY = 2'b01;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_rd_arbiter_rr_arbiter.sv
// Round-robin one-hot arbiter; the search starts one lane past the last winner.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          upd_en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr_q, ptr_d;

  // Scan lanes ptr+1 .. ptr+N and take the first requester
  always_comb begin : scan
    logic        found;
    int unsigned c;
    found     = 1'b0;
    c         = 0;
    grant     = '0;
    grant_idx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      c = (32'(ptr_q) + k) % N;
      if (!found && req[c]) begin
        found     = 1'b1;
        grant[c]  = 1'b1;
        grant_idx = IW'(c);
      end
    end
  end

  // Move the pointer only when a grant is actually taken
  always_comb begin
    ptr_d = ptr_q;
    if (upd_en && (|req)) ptr_d = grant_idx;
  end

  // Pointer resets to the last lane so lane 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= IW'(N - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read port among NUM_AXI requesters, one burst in flight.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned NUM_AXI    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 6,
  parameter int unsigned LEN_WIDTH  = 4,
  localparam int unsigned IW = (NUM_AXI > 1) ? $clog2(NUM_AXI) : 1
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [ADDR_WIDTH*NUM_AXI-1:0] S_AXI_ARADDR,
  input  logic [LEN_WIDTH*NUM_AXI-1:0]  S_AXI_ARLEN,
  input  logic [ID_WIDTH*NUM_AXI-1:0]   S_AXI_ARID,
  input  logic [NUM_AXI-1:0]            S_AXI_ARVALID,
  output logic [NUM_AXI-1:0]            S_AXI_ARREADY,
  output logic [DATA_WIDTH*NUM_AXI-1:0] S_AXI_RDATA,
  output logic [2*NUM_AXI-1:0]          S_AXI_RRESP,
  output logic [NUM_AXI-1:0]            S_AXI_RLAST,
  output logic [NUM_AXI-1:0]            S_AXI_RVALID,
  input  logic [NUM_AXI-1:0]            S_AXI_RREADY,
  output logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR,
  output logic [LEN_WIDTH-1:0]          M_AXI_ARLEN,
  output logic [ID_WIDTH-1:0]           M_AXI_ARID,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]         M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic [IW-1:0]                 grant_idx,
  output logic                          err_len
);

  rd_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]  araddr_q, araddr_d;
  logic [LEN_WIDTH-1:0]   arlen_q, arlen_d;
  logic [ID_WIDTH-1:0]    arid_q, arid_d;
  logic [NUM_AXI-1:0]     arready_q, arready_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   arb_upd;
  logic [NUM_AXI-1:0]     arb_grant;
  logic [IW-1:0]          arb_idx;
  logic                   r_hs;

  rr_arbiter #(.N(NUM_AXI)) u_rr (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .req       (S_AXI_ARVALID),
    .upd_en    (arb_upd),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // State register and all datapath flops
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arid_q    <= '0;
      arready_q <= '0;
      gidx_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arid_q    <= arid_d;
      arready_q <= arready_d;
      gidx_q    <= gidx_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Next state: grant and latch in IDLE, wait for AR handshake, count beats
  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arid_d    = arid_q;
    arready_d = '0;
    gidx_d    = gidx_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    arb_upd   = 1'b0;
    r_hs      = M_AXI_RVALID && S_AXI_RREADY[gidx_q];
    unique case (state_q)
      IDLE: begin
        if (|S_AXI_ARVALID) begin
          arb_upd   = 1'b1;
          gidx_d    = arb_idx;
          araddr_d  = S_AXI_ARADDR[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
          arlen_d   = S_AXI_ARLEN[arb_idx*LEN_WIDTH +: LEN_WIDTH];
          arid_d    = S_AXI_ARID[arb_idx*ID_WIDTH +: ID_WIDTH];
          arready_d = arb_grant;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (M_AXI_ARREADY) begin
          cnt_d   = arlen_q;
          state_d = DATA;
        end
      end
      DATA: begin
        if (r_hs) begin
          cnt_d = cnt_q - LEN_WIDTH'(1);
          // RLAST must coincide exactly with the counter reaching zero
          if (M_AXI_RLAST != (cnt_q == '0)) err_d = 1'b1;
          if (M_AXI_RLAST) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: AR side from registers, R side steered to the granted lane
  always_comb begin
    M_AXI_ARVALID = (state_q == ADDR);
    M_AXI_RREADY  = 1'b0;
    S_AXI_RVALID  = '0;
    S_AXI_RLAST   = '0;
    S_AXI_RDATA   = {NUM_AXI{M_AXI_RDATA}};
    S_AXI_RRESP   = {NUM_AXI{M_AXI_RRESP}};
    if (state_q == DATA) begin
      M_AXI_RREADY         = S_AXI_RREADY[gidx_q];
      S_AXI_RVALID[gidx_q] = M_AXI_RVALID;
      S_AXI_RLAST[gidx_q]  = M_AXI_RLAST;
    end
  end

  assign S_AXI_ARREADY = arready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARLEN   = arlen_q;
  assign M_AXI_ARID    = arid_q;
  assign grant_idx     = gidx_q;
  assign err_len       = err_q;

endmodule
